// File: rtl/grid_move_engine.sv
// grid_move_engine -- tile map owner and movement engine for N players.
//
// Keeps a MAP_W x MAP_H tile map in flops. A round starts on `start`: INIT
// paints one column per cycle (frame border, empty interior, start tiles).
// Every accepted `step` then moves each living player by one tile. EVAL
// spends one cycle per player checking its target against an unchanged map
// snapshot. COMMIT writes all survivors together, so the outcome does not
// depend on player order.
//
// Optional build macro: GRID_WRAP_EN -- toroidal map. No frame is drawn,
// moves wrap at the edges, and no move is ever out of range.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   start, step     round start / movement tick pulses
//   dir             3 bits per player: 0 wait, 1 right, 2 left, 3 down, 4 up
//   start_x/y       per-player start tile, sampled on an accepted start
//   rd_x/y, rd_tile renderer read port, one cycle latency, EMPTY off-map
//   pos_x/y         per-player head position
//   alive           per-player alive flags
//   collision       one-cycle pulse per player that died on the last step
//   busy            high while in INIT, EVAL or COMMIT
//   step_done       one-cycle pulse when a step's results are visible
//   game_over       high in OVER
//   winner_valid    high in OVER when exactly one player survives
//   winner          index of that survivor
//   step_overrun    sticky: a step arrived outside RUN; cleared by start

// Per-player next-position logic.
module grid_move_lane #(
  parameter int COORD_W = 8,
  parameter int MAP_W   = 64,
  parameter int MAP_H   = 48
) (
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input  logic [2:0]         dir,
  input  logic               alive,
  output logic [COORD_W-1:0] nxt_x,
  output logic [COORD_W-1:0] nxt_y,
  output logic               moving,
  output logic               oob
);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
`ifdef GRID_WRAP_EN
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MAP_H - 1);
`endif

  always_comb begin
    nxt_x  = cur_x;
    nxt_y  = cur_y;
    moving = 1'b0;
    if (alive) begin
      case (dir)
        3'd1: begin
          moving = 1'b1;
`ifdef GRID_WRAP_EN
          nxt_x = (cur_x == X_MAX) ? '0 : cur_x + ONE;
`else
          nxt_x = cur_x + ONE;
`endif
        end
        3'd2: begin
          moving = 1'b1;
`ifdef GRID_WRAP_EN
          nxt_x = (cur_x == '0) ? X_MAX : cur_x - ONE;
`else
          nxt_x = cur_x - ONE;
`endif
        end
        3'd3: begin
          moving = 1'b1;
`ifdef GRID_WRAP_EN
          nxt_y = (cur_y == Y_MAX) ? '0 : cur_y + ONE;
`else
          nxt_y = cur_y + ONE;
`endif
        end
        3'd4: begin
          moving = 1'b1;
`ifdef GRID_WRAP_EN
          nxt_y = (cur_y == '0) ? Y_MAX : cur_y - ONE;
`else
          nxt_y = cur_y - ONE;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef GRID_WRAP_EN
  assign oob = 1'b0;
`else
  // Underflow from 0 wraps to a large value and therefore lands here too.
  assign oob = moving && (({1'b0, nxt_x} >= (COORD_W+1)'(MAP_W)) ||
                          ({1'b0, nxt_y} >= (COORD_W+1)'(MAP_H)));
`endif
endmodule

module grid_move_engine #(
  parameter int N_PLAYERS = 2,
  parameter int MAP_W     = 64,
  parameter int MAP_H     = 48,
  parameter int COORD_W   = 8,
  parameter int TILE_W    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           step,
  input  logic [3*N_PLAYERS-1:0]         dir,
  input  logic [COORD_W*N_PLAYERS-1:0]   start_x,
  input  logic [COORD_W*N_PLAYERS-1:0]   start_y,
  input  logic [COORD_W-1:0]             rd_x,
  input  logic [COORD_W-1:0]             rd_y,
  output logic [TILE_W-1:0]              rd_tile,
  output logic [COORD_W*N_PLAYERS-1:0]   pos_x,
  output logic [COORD_W*N_PLAYERS-1:0]   pos_y,
  output logic [N_PLAYERS-1:0]           alive,
  output logic [N_PLAYERS-1:0]           collision,
  output logic                           busy,
  output logic                           step_done,
  output logic                           game_over,
  output logic                           winner_valid,
  output logic [1:0]                     winner,
  output logic                           step_overrun
);
  localparam int XW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int YW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam logic [TILE_W-1:0]  T_EMPTY = '0;
`ifndef GRID_WRAP_EN
  localparam logic [TILE_W-1:0]  T_FRAME = TILE_W'(1);
`endif
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);
  localparam logic [PW-1:0]      E_LAST  = PW'(N_PLAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RUN, S_EVAL, S_COMMIT, S_OVER
  } state_t;

  state_t state, state_nxt;

  logic [TILE_W-1:0] map [MAP_H][MAP_W];

  logic [N_PLAYERS-1:0][COORD_W-1:0] sx, sy, px, py;
  logic [N_PLAYERS-1:0][COORD_W-1:0] lane_nx, lane_ny, nx_q, ny_q;
  logic [N_PLAYERS-1:0]              lane_mov, lane_oob, mov_q, oob_q;
  logic [N_PLAYERS-1:0]              alive_q, die_q, coll_q;
  logic                              done_q, overrun_q;
  logic [TILE_W-1:0]                 rd_q;
  logic [COORD_W-1:0]                init_col;
  logic [PW-1:0]                     eval_idx;

  function automatic logic in_map(input logic [COORD_W-1:0] x,
                                  input logic [COORD_W-1:0] y);
    return ({1'b0, x} < (COORD_W+1)'(MAP_W)) &&
           ({1'b0, y} < (COORD_W+1)'(MAP_H));
  endfunction

  function automatic logic [TILE_W-1:0] tile_at(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    if (in_map(x, y)) return map[y[YW-1:0]][x[XW-1:0]];
    return T_EMPTY;
  endfunction

  // Next positions come from the live head positions; they are latched on the
  // accepted step so a dir change during EVAL cannot disturb the step.
  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_lane
    grid_move_lane #(.COORD_W(COORD_W), .MAP_W(MAP_W), .MAP_H(MAP_H)) u_lane (
      .cur_x  (px[g]),
      .cur_y  (py[g]),
      .dir    (dir[3*g +: 3]),
      .alive  (alive_q[g]),
      .nxt_x  (lane_nx[g]),
      .nxt_y  (lane_ny[g]),
      .moving (lane_mov[g]),
      .oob    (lane_oob[g])
    );
  end

  // Contents of the column INIT paints this cycle. Later players are applied
  // last so they win when start tiles coincide.
  logic [TILE_W-1:0] col_val [MAP_H];
  always_comb begin
    for (int y = 0; y < MAP_H; y++) begin
`ifdef GRID_WRAP_EN
      col_val[y] = T_EMPTY;
`else
      col_val[y] = (y == 0 || y == MAP_H - 1 || init_col == '0 ||
                    init_col == X_LAST) ? T_FRAME : T_EMPTY;
`endif
      for (int p = 0; p < N_PLAYERS; p++)
        if (sx[p] == init_col && sy[p] == COORD_W'(y))
          col_val[y] = TILE_W'(p + 2);
    end
  end

  // Verdict for the player under evaluation. mov_q already excludes dead and
  // waiting players, so they never die and never cause a head-on.
  logic [COORD_W-1:0] ex, ey;
  logic               e_hit, e_die;
  always_comb begin
    ex    = nx_q[eval_idx];
    ey    = ny_q[eval_idx];
    e_hit = 1'b0;
    for (int q = 0; q < N_PLAYERS; q++)
      if (PW'(q) != eval_idx && mov_q[q] && nx_q[q] == ex && ny_q[q] == ey)
        e_hit = 1'b1;
    e_die = mov_q[eval_idx] &&
            (oob_q[eval_idx] || tile_at(ex, ey) != T_EMPTY || e_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_OVER: if (start) state_nxt = S_INIT;
      S_INIT:         if (init_col == X_LAST) state_nxt = S_RUN;
      S_RUN:          if (step) state_nxt = S_EVAL;
      S_EVAL:         if (eval_idx == E_LAST) state_nxt = S_COMMIT;
      S_COMMIT:       state_nxt = ($countones(alive_q & ~die_q) <= 1) ? S_OVER : S_RUN;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int y = 0; y < MAP_H; y++)
        for (int x = 0; x < MAP_W; x++)
          map[y][x] <= T_EMPTY;
      sx        <= '0;
      sy        <= '0;
      px        <= '0;
      py        <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      mov_q     <= '0;
      oob_q     <= '0;
      alive_q   <= '0;
      die_q     <= '0;
      coll_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      rd_q      <= T_EMPTY;
      init_col  <= '0;
      eval_idx  <= '0;
    end else begin
      coll_q <= '0;
      done_q <= 1'b0;
      rd_q   <= tile_at(rd_x, rd_y);
      // Set before the state case so an accepted start in the same cycle
      // still clears the flag.
      if (step && state != S_RUN) overrun_q <= 1'b1;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            sx        <= start_x;
            sy        <= start_y;
            px        <= start_x;
            py        <= start_y;
            alive_q   <= '1;
            init_col  <= '0;
            overrun_q <= 1'b0;
          end
        end
        S_INIT: begin
          for (int y = 0; y < MAP_H; y++)
            map[y][init_col[XW-1:0]] <= col_val[y];
          init_col <= init_col + ONE;
        end
        S_RUN: begin
          if (step) begin
            nx_q     <= lane_nx;
            ny_q     <= lane_ny;
            mov_q    <= lane_mov;
            oob_q    <= lane_oob;
            die_q    <= '0;
            eval_idx <= '0;
          end
        end
        S_EVAL: begin
          die_q[eval_idx] <= e_die;
          eval_idx        <= eval_idx + PW'(1);
        end
        S_COMMIT: begin
          // Survivors have distinct targets (a shared target kills everyone
          // involved), so these writes never overlap.
          for (int p = 0; p < N_PLAYERS; p++) begin
            if (mov_q[p] && !die_q[p] && in_map(nx_q[p], ny_q[p])) begin
              map[ny_q[p][YW-1:0]][nx_q[p][XW-1:0]] <= TILE_W'(p + 2);
              px[p] <= nx_q[p];
              py[p] <= ny_q[p];
            end
          end
          alive_q <= alive_q & ~die_q;
          coll_q  <= die_q;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [1:0] win_idx;
  always_comb begin
    win_idx = '0;
    for (int p = 0; p < N_PLAYERS; p++)
      if (alive_q[p]) win_idx = 2'(p);
  end

  assign rd_tile      = rd_q;
  assign pos_x        = px;
  assign pos_y        = py;
  assign alive        = alive_q;
  assign collision    = coll_q;
  assign step_done    = done_q;
  assign step_overrun = overrun_q;
  assign busy         = (state == S_INIT) || (state == S_EVAL) || (state == S_COMMIT);
  assign game_over    = (state == S_OVER);
  assign winner_valid = game_over && ($countones(alive_q) == 1);
  assign winner       = winner_valid ? win_idx : 2'd0;
endmodule
